flexbex_ibex_fetch_fifo: RTL and testbench

Realigning instruction fetch FIFO that sits directly upstream of flexbex_ibex_compressed_decoder. It buffers 32-bit word-aligned fetch responses from instruction memory. It presents one 32-bit candidate instruction per cycle, aligned to the current PC, to the decoder. It handles mixed 16/32-bit instruction streams, including 32-bit instructions that straddle a word boundary, and tracks the PC of the presented instruction.

---
 rtl/flexbex_ibex_fetch_fifo.sv | 137 +++++++++++++
 tb/tb_flexbex_ibex_fetch_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexbex_ibex_fetch_fifo.sv
// Realigning instruction fetch FIFO: buffers word-aligned fetch responses and presents
// one PC-aligned candidate instruction per cycle. Optional macro: FETCH_FIFO_BYPASS_EN.
module flexbex_ibex_fetch_fifo #(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [31:0]       in_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_rdata_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]       entries_q [DEPTH];
    logic [31:0]       entries_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              seeded_q, seeded_d;

    logic              push;
    logic              pop_fire;
    logic              pop_entry;
    logic              misaligned;
    logic              comp;
    logic              wr;
    logic [CNT_W-1:0]  widx;
    logic [ADDR_W-1:0] pc_cur;
    logic [31:0]       head0;
    logic [CNT_W-1:0]  avail;

    assign in_ready_o = (count_q < CNT_W'(DEPTH));
    assign push       = in_valid_i && in_ready_o;

    // head0/avail describe the word at the front of the stream, which the bypass
    // path may source straight from the input port while the FIFO is empty.
`ifdef FETCH_FIFO_BYPASS_EN
    logic byp;
    assign byp    = (count_q == '0) && in_valid_i && !clear_i;
    assign pc_cur = (byp && !seeded_q) ? in_addr_i : pc_q;
    assign head0  = byp ? in_rdata_i : entries_q[0];
    assign avail  = byp ? CNT_W'(1) : count_q;
`else
    assign pc_cur = pc_q;
    assign head0  = entries_q[0];
    assign avail  = count_q;
`endif

    assign misaligned = pc_cur[1];

    always_comb begin
        out_rdata_o = head0;
        out_valid_o = (avail >= CNT_W'(1));
        if (misaligned) begin
            out_rdata_o[15:0]  = head0[31:16];
            out_rdata_o[31:16] = (avail == CNT_W'(1)) ? 16'h0000 : entries_q[1][15:0];
            out_valid_o        = (avail >= CNT_W'(2)) ||
                                 ((avail >= CNT_W'(1)) && (head0[17:16] != 2'b11));
        end
    end

    assign out_addr_o = pc_cur;
    assign comp       = (out_rdata_o[1:0] != 2'b11);
    assign pop_fire   = out_valid_o && out_ready_i && !clear_i;
    // An aligned compressed instruction leaves the upper halfword still to be consumed.
    assign pop_entry  = pop_fire && (misaligned || !comp);

    always_comb begin
        count_d   = count_q;
        pc_d      = pc_q;
        seeded_d  = seeded_q;
        wr        = 1'b0;
        widx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end

        if (clear_i) begin
            count_d  = in_valid_i ? CNT_W'(1) : '0;
            seeded_d = in_valid_i;
            wr       = in_valid_i;
            if (in_valid_i) begin
                pc_d = in_addr_i;
            end
        end else begin
            if (pop_entry) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entries_d[i] = entries_q[i + 1];
                end
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop_entry);
            // A bypassed word that is fully consumed in its arrival cycle is not stored.
            wr      = push && !((count_q == '0) && pop_entry);
            widx    = count_q - CNT_W'(pop_entry);

            if (pop_fire) begin
                pc_d     = pc_cur + (comp ? ADDR_W'(2) : ADDR_W'(4));
                seeded_d = 1'b1;
            end else if (push && !seeded_q) begin
                pc_d     = in_addr_i;
                seeded_d = 1'b1;
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (wr && (widx == CNT_W'(i))) begin
                entries_d[i] = in_rdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            pc_q     <= '0;
            seeded_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            pc_q     <= pc_d;
            seeded_q <= seeded_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: tb/tb_flexbex_ibex_fetch_fifo.sv
// Scoreboard bench for flexbex_ibex_fetch_fifo: a halfword-stream reference model predicts
// the instruction sequence; a monitor compares every consumed instruction.
module tb_flexbex_ibex_fetch_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_addr_i;
    logic [31:0] in_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          comp;
    } instr_t;

    instr_t      exp_q[$];
    logic [15:0] hwq[$];
    logic [31:0] mpc;
    bit          mseeded;

    flexbex_ibex_fetch_fifo #(.DEPTH(3), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_addr_i   (in_addr_i),
        .in_rdata_i  (in_rdata_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_rdata_o (out_rdata_o),
        .out_addr_o  (out_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        hwq.delete();
        mseeded = 1'b0;
    endtask

    // Reference model: the fetch stream is a sequence of halfwords starting at the seed PC;
    // an instruction is complete once all of its halfwords have arrived.
    task automatic model_push(input logic [31:0] a, input logic [31:0] w);
        instr_t e;
        logic [15:0] lo;
        if (!mseeded) begin
            mseeded = 1'b1;
            mpc = a;
            if (!a[1]) hwq.push_back(w[15:0]);
            hwq.push_back(w[31:16]);
        end else begin
            hwq.push_back(w[15:0]);
            hwq.push_back(w[31:16]);
        end
        while (hwq.size() > 0) begin
            lo = hwq[0];
            if (lo[1:0] != 2'b11) begin
                e.addr = mpc; e.data = {16'h0, lo}; e.comp = 1'b1;
                exp_q.push_back(e);
                void'(hwq.pop_front());
                mpc = mpc + 32'd2;
            end else if (hwq.size() >= 2) begin
                e.addr = mpc; e.data = {hwq[1], lo}; e.comp = 1'b0;
                exp_q.push_back(e);
                void'(hwq.pop_front());
                void'(hwq.pop_front());
                mpc = mpc + 32'd4;
            end else begin
                break;
            end
        end
    endtask

    // Monitor: samples on the falling edge, between active edges.
    initial begin
        instr_t e;
        model_flush();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_flush();
            end else if (clear_i) begin
                model_flush();
                if (in_valid_i) model_push(in_addr_i, in_rdata_i);
            end else begin
                if (out_valid_o && out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_pop actual=%h@%h expected=none", out_rdata_o, out_addr_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_addr", out_addr_o, e.addr);
                        if (e.comp) chk("pop_cdata", {16'h0, out_rdata_o[15:0]}, e.data);
                        else        chk("pop_data", out_rdata_o, e.data);
                    end
                end
                if (in_valid_i && in_ready_o) model_push(in_addr_i, in_rdata_i);
            end
        end
    end

    task automatic drive(input bit v, input bit rdy, input bit clr,
                         input logic [31:0] a, input logic [31:0] d);
        in_valid_i  = v;
        out_ready_i = rdy;
        clear_i     = clr;
        in_addr_i   = a;
        in_rdata_i  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(1, 0) == 1) w[1:0] = 2'b11;
        if ($urandom_range(1, 0) == 1) w[17:16] = 2'b11;
        return w;
    endfunction

    function automatic logic [31:0] new_seed();
        logic [31:0] x;
        x = $urandom & 32'hFFFF_FFFE;
        if ($urandom_range(3, 0) == 0) x = 32'hFFFF_FFF0 | (x & 32'h0000_000E);
        return x;
    endfunction

    initial begin
        logic [31:0] drv_addr;
        bit v, rdy, clr, acc;
        logic [31:0] w;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid_o}, 32'h0);
        chk("rst_out_addr", out_addr_o, 32'h0);
        chk("rst_out_rdata", out_rdata_o, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready_o}, 32'h1);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Aligned 32-bit instruction
        drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h00B5_0533);
        chk("t1_valid", {31'h0, out_valid_o}, 32'h1);
        chk("t1_addr", out_addr_o, 32'h100);
        chk("t1_rdata", out_rdata_o, 32'h00B5_0533);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("t1_valid_after_pop", {31'h0, out_valid_o}, 32'h0);
        chk("t1_addr_after_pop", out_addr_o, 32'h104);

        // Two compressed instructions in one word
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h200, 32'h4501_4505);
        chk("t2_addr0", out_addr_o, 32'h200);
        chk("t2_hw0", {16'h0, out_rdata_o[15:0]}, 32'h4505);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("t2_valid1", {31'h0, out_valid_o}, 32'h1);
        chk("t2_addr1", out_addr_o, 32'h202);
        chk("t2_hw1", {16'h0, out_rdata_o[15:0]}, 32'h4501);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("t2_valid_end", {31'h0, out_valid_o}, 32'h0);
        chk("t2_addr_end", out_addr_o, 32'h204);

        // Misaligned straddling 32-bit instruction
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h302, 32'h0533_1234);
        chk("t3_wait_valid", {31'h0, out_valid_o}, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h304, 32'hABCD_00B5);
        chk("t3_valid", {31'h0, out_valid_o}, 32'h1);
        chk("t3_rdata", out_rdata_o, 32'h00B5_0533);
        chk("t3_addr", out_addr_o, 32'h302);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("t3_addr_after", out_addr_o, 32'h306);
        drain(4);

        // Full FIFO back-pressure
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h600, 32'h0000_0013);
        drive(1'b1, 1'b0, 1'b0, 32'h604, 32'h0010_0093);
        drive(1'b1, 1'b0, 1'b0, 32'h608, 32'h0020_0113);
        chk("t4_full_ready", {31'h0, in_ready_o}, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h60C, 32'hDEAD_BEEF);
        chk("t4_ignored_ready", {31'h0, in_ready_o}, 32'h0);
        chk("t4_ignored_head", out_rdata_o, 32'h0000_0013);
        drive(1'b1, 1'b1, 1'b0, 32'h60C, 32'h0030_0193);
        chk("t4_ready_rises", {31'h0, in_ready_o}, 32'h1);
        chk("t4_head_after_pop", out_rdata_o, 32'h0010_0093);
        drive(1'b1, 1'b0, 1'b0, 32'h60C, 32'h0030_0193);
        chk("t4_full_again", {31'h0, in_ready_o}, 32'h0);
        drain(6);

        // Clear with simultaneous push
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h500, 32'h1111_1113);
        drive(1'b1, 1'b0, 1'b0, 32'h504, 32'h2222_2223);
        drive(1'b1, 1'b1, 1'b1, 32'h400, 32'h0000_0013);
        chk("t5_addr", out_addr_o, 32'h400);
        chk("t5_rdata", out_rdata_o, 32'h0000_0013);
        chk("t5_valid", {31'h0, out_valid_o}, 32'h1);
        drain(3);

        // PC wrap-around and asynchronous reset
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h00B5_0533);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("t6_wrap_addr", out_addr_o, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h4505_4505);
        chk("t6_valid_pre_rst", {31'h0, out_valid_o}, 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'h0, out_valid_o}, 32'h0);
        chk("t6_async_addr", out_addr_o, 32'h0);
        chk("t6_async_ready", {31'h0, in_ready_o}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized mixed stream
        drv_addr = new_seed();
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(9, 0) < 7);
            rdy = ($urandom_range(9, 0) < 6);
            clr = (i == 0) || (($urandom_range(49, 0) == 0) && in_ready_o);
            if (clr) drv_addr = new_seed();
            w   = rand_word();
            acc = v && (in_ready_o || clr);
            drive(v, rdy, clr, drv_addr, w);
            if (acc) drv_addr = {drv_addr[31:2], 2'b00} + 32'd4;
        end
        drain(20);
        chk("final_queue_empty", exp_q.size(), 32'h0);
        chk("final_valid", {31'h0, out_valid_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
